// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the Core-to-block-RAM memory bridge.
//   size_e         - Core access size encoding (00 byte, 01 half, 1x word)
//   bridge_state_e - mem_bridge FSM state encoding (also used on its debug port)
//   size_bytes()   - access size in bytes for a size code
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_CAP  = 3'd3,
    ST_RESP = 3'd4
  } bridge_state_e;

  // Code 2'b11 is treated as a word, same as the Core's data_size.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: places an LSB-aligned write onto the RAM byte lanes for
// one beat of a (possibly word-crossing) access. Purely combinational.
//   off_i   - byte offset within the first word (addr[1:0])
//   size_i  - access size code
//   wdata_i - LSB-aligned write data
//   beat_i  - 0: first word, 1: second word of a crossing access
//   be_o    - per-lane byte enables for this beat
//   wdata_o - lane-positioned write data for this beat
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic        beat_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  logic [2:0]  n;
  logic [3:0]  mask;
  logic [7:0]  be_wide;
  logic [63:0] data_wide;

  // Shift the access into an 8-lane (two-word) window; the low half is the
  // first beat and the high half is whatever spilled into the next word.
  always_comb begin
    n = size_bytes(size_i);
    case (n)
      3'd1:    mask = 4'b0001;
      3'd2:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    be_wide   = {4'b0000, mask} << off_i;
    data_wide = {32'd0, wdata_i} << {off_i, 3'b000};
    be_o      = beat_i ? be_wide[7:4] : be_wide[3:0];
    wdata_o   = beat_i ? data_wide[63:32] : data_wide[31:0];
  end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: adapts the Core's byte-addressed, variable-size memory port to a
// 32-bit synchronous block RAM with byte enables. Word-crossing accesses are
// split into two RAM beats; read data is returned LSB-aligned, zero-extended.
//   clk, rst_n            - clock, synchronous active-low reset
//   req_valid/req_ready   - request handshake from the Core
//   req_addr/size/we/wdata- request fields, registered on accept
//   rsp_valid/rdata/err   - one-cycle completion pulse with read data / error
//   ram_en/we/addr/wdata  - block RAM port (registered outputs)
//   ram_rdata             - RAM read data, valid the cycle after a read beat
//   dbg_state             - current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE, so one request is in
// flight at a time; the request inputs are free to change after that edge.
// rsp_valid is high for exactly one cycle per accepted request unless the
// request is aborted by reset.
module mem_bridge
  import mem_pkg::*;
#(
  parameter int RAM_AW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_we,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output bridge_state_e     dbg_state
);

  localparam logic [30:0] WORDS = 31'd1 << RAM_AW;

  bridge_state_e     state_q;
  logic              rsp_valid_q, rsp_err_q, ram_en_q;
  logic [31:0]       rsp_rdata_q, ram_wdata_q;
  logic [3:0]        ram_we_q;
  logic [RAM_AW-1:0] ram_addr_q, w1_q;
  logic [1:0]        off_q, size_q;
  logic              we_q, span_q;
  logic [31:0]       wdata_q, lo_q;

  // Decode of the live request, used only on the accept edge.
  logic [1:0]  acc_off;
  logic [2:0]  acc_n;
  logic        acc_span, acc_err;
  logic [29:0] acc_w0;
  logic [30:0] acc_w1;

  always_comb begin
    acc_off  = req_addr[1:0];
    acc_n    = size_bytes(req_size);
    acc_span = ({2'b00, acc_off} + {1'b0, acc_n}) > 4'd4;
    acc_w0   = req_addr[31:2];
    // One extra bit so a wrap past the top of the address space still
    // compares as out of range.
    acc_w1   = {1'b0, acc_w0} + 31'd1;
    acc_err  = ({1'b0, acc_w0} >= WORDS) || (acc_span && (acc_w1 >= WORDS));
  end

  // The aligner sees the live request while idle (first beat is launched on
  // the accept edge) and the registered copy afterwards (second beat).
  logic        al_beat;
  logic [1:0]  al_off, al_size;
  logic [31:0] al_wdata_in, al_wdata;
  logic [3:0]  al_be;

  always_comb begin
    al_beat     = (state_q != ST_IDLE);
    al_off      = al_beat ? off_q   : acc_off;
    al_size     = al_beat ? size_q  : req_size;
    al_wdata_in = al_beat ? wdata_q : req_wdata;
  end

  mem_lane_align u_align (
    .off_i   (al_off),
    .size_i  (al_size),
    .wdata_i (al_wdata_in),
    .beat_i  (al_beat),
    .be_o    (al_be),
    .wdata_o (al_wdata)
  );

  // {hi, lo} shifted down by the byte offset, then trimmed to the access size.
  function automatic logic [31:0] assemble(input logic [31:0] hi, input logic [31:0] lo,
                                           input logic [1:0] off, input logic [1:0] size);
    logic [31:0] sh;
    sh = 32'({hi, lo} >> {off, 3'b000});
    case (size_bytes(size))
      3'd1:    return {24'd0, sh[7:0]};
      3'd2:    return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      off_q       <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      span_q      <= 1'b0;
      w1_q        <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            off_q   <= acc_off;
            size_q  <= req_size;
            we_q    <= req_we;
            span_q  <= acc_span;
            wdata_q <= req_wdata;
            w1_q    <= acc_w1[RAM_AW-1:0];
            if (acc_err) begin
              // Rejected before any beat, so nothing is ever written.
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= ST_B0;
              ram_en_q    <= 1'b1;
              ram_addr_q  <= acc_w0[RAM_AW-1:0];
              ram_we_q    <= req_we ? al_be : 4'b0000;
              ram_wdata_q <= req_we ? al_wdata : 32'd0;
            end
          end
        end
        ST_B0: begin
          if (span_q) begin
            state_q     <= ST_B1;
            ram_addr_q  <= w1_q;
            ram_we_q    <= we_q ? al_be : 4'b0000;
            ram_wdata_q <= we_q ? al_wdata : 32'd0;
          end else begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= '0;
            ram_wdata_q <= '0;
            if (we_q) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= ST_CAP;
            end
          end
        end
        ST_B1: begin
          ram_en_q    <= 1'b0;
          ram_we_q    <= '0;
          ram_wdata_q <= '0;
          // First-beat read data arrives now.
          lo_q        <= ram_rdata;
          if (we_q) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end else begin
            state_q <= ST_CAP;
          end
        end
        ST_CAP: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= span_q ? assemble(ram_rdata, lo_q, off_q, size_q)
                                : assemble(32'd0, ram_rdata, off_q, size_q);
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: self-checking bench for mem_bridge with a behavioural block
// RAM, a byte-level reference memory and an in-order response scoreboard.
module tb_mem_bridge;
  import mem_pkg::*;

  localparam int RAM_AW = 14;
  localparam int W      = 36;  // {err, latency[2:0], rdata[31:0]}

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [31:0]       req_addr, req_wdata;
  logic [1:0]        req_size;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  bridge_state_e     dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [W-1:0]  exp_q[$];
  int            acc_q[$];
  logic [49:0]   beat_q[$];  // {addr, we, wdata} seen on the RAM port
  logic [7:0]    ref_mem [0:65535];
  logic [31:0]   ram [0:(1<<RAM_AW)-1];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= ram[ram_addr];
    end
  end

  mem_bridge #(.RAM_AW(RAM_AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- driver ----------------
  // Called at a negedge. Expected response comes from the reference memory.
  task automatic send(input logic [31:0] addr, input logic [1:0] size, input logic we,
                      input logic [31:0] wdata, output int acc);
    int          n, lat;
    logic        span, err;
    longint      w0;
    logic [31:0] exp_rd;
    n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    span = (int'(addr[1:0]) + n) > 4;
    w0   = longint'(addr[31:2]);
    err  = (w0 >= 16384) || (span && (w0 + 1) >= 16384);
    req_addr  = addr;
    req_size  = size;
    req_we    = we;
    req_wdata = wdata;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready === 1'b1) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL accept_timeout addr=%h: req_ready never 1 within 50 cycles", addr);
      req_valid = 1'b0;
      return;
    end
    exp_rd = '0;
    if (!err)
      for (int i = 0; i < n; i++)
        if (we) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
        else    exp_rd[8*i +: 8] = ref_mem[int'(addr) + i];
    lat = err ? 1 : we ? (span ? 3 : 2) : (span ? 4 : 3);
    exp_q.push_back({err, 3'(lat), exp_rd});
    acc_q.push_back(acc);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor();
    logic [W-1:0] e;
    int           a, lat;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        checks++;
        if (req_ready !== (dbg_state == ST_IDLE)) begin
          errors++;
          $display("FAIL ready_state: req_ready=%b state=%0d", req_ready, dbg_state);
        end
        if (dbg_state != ST_B0 && dbg_state != ST_B1) begin
          checks++;
          if (ram_en !== 1'b0 || ram_we !== 4'b0000) begin
            errors++;
            $display("FAIL ram_idle: ram_en=%b ram_we=%b state=%0d, required 0/0000",
                     ram_en, ram_we, dbg_state);
          end
        end
        if (ram_en === 1'b1) beat_q.push_back({ram_addr, ram_we, ram_wdata});
        if (rsp_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding");
          end else begin
            e   = exp_q.pop_front();
            a   = acc_q.pop_front();
            lat = cyc - a + 1;
            checks += 3;
            if (rsp_rdata !== e[31:0]) begin
              errors++;
              $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, e[31:0]);
            end
            if (rsp_err !== e[35]) begin
              errors++;
              $display("FAIL rsp_err: got %b required %b", rsp_err, e[35]);
            end
            if (lat != int'(e[34:32])) begin
              errors++;
              $display("FAIL latency: got %0d required %0d", lat, e[34:32]);
            end
          end
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 8;
    if (req_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b required 1", req_ready); end
    if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    if (rsp_err !== 1'b0)    begin errors++; $display("FAIL reset_rsp_err: got %b required 0", rsp_err); end
    if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h required 0", rsp_rdata); end
    if (ram_en !== 1'b0)     begin errors++; $display("FAIL reset_ram_en: got %b required 0", ram_en); end
    if (ram_we !== 4'd0)     begin errors++; $display("FAIL reset_ram_we: got %b required 0", ram_we); end
    if (ram_addr !== '0)     begin errors++; $display("FAIL reset_ram_addr: got %h required 0", ram_addr); end
    if (ram_wdata !== 32'd0) begin errors++; $display("FAIL reset_ram_wdata: got %h required 0", ram_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_beat(input string name, input int idx, input logic [49:0] exp,
                            input logic full);
    checks++;
    if (beat_q.size() <= idx) begin
      errors++;
      $display("FAIL %s: beat %0d missing, %0d beats seen", name, idx, beat_q.size());
    end else if (full ? (beat_q[idx] !== exp) : (beat_q[idx][49:32] !== exp[49:32])) begin
      errors++;
      $display("FAIL %s: beat %0d got %h required %h", name, idx, beat_q[idx], exp);
    end
  endtask

  task automatic check_nbeats(input string name, input int n);
    checks++;
    if (beat_q.size() != n) begin
      errors++;
      $display("FAIL %s: got %0d RAM beats required %0d", name, beat_q.size(), n);
    end
  endtask

  task automatic test_word();
    int a;
    beat_q.delete();
    send(32'h10, 2'b10, 1'b1, 32'hDEADBEEF, a);
    wait_done();
    check_nbeats("word_wr_beats", 1);
    check_beat("word_wr_b0", 0, {14'd4, 4'b1111, 32'hDEADBEEF}, 1'b1);
    beat_q.delete();
    send(32'h10, 2'b10, 1'b0, 32'h0, a);
    wait_done();
    check_nbeats("word_rd_beats", 1);
    check_beat("word_rd_b0", 0, {14'd4, 4'b0000, 32'h0}, 1'b0);
  endtask

  task automatic test_subword();
    int a;
    beat_q.delete();
    send(32'h13, 2'b00, 1'b0, 32'h0, a);
    wait_done();
    check_beat("byte_rd_b0", 0, {14'd4, 4'b0000, 32'h0}, 1'b0);
    send(32'h12, 2'b01, 1'b0, 32'h0, a);
    send(32'h11, 2'b01, 1'b0, 32'h0, a);
    send(32'h10, 2'b00, 1'b0, 32'h0, a);
    wait_done();
  endtask

  task automatic test_span();
    int a;
    beat_q.delete();
    send(32'h0E, 2'b10, 1'b1, 32'h11223344, a);
    wait_done();
    check_nbeats("span_wr_beats", 2);
    check_beat("span_wr_b0", 0, {14'd3, 4'b1100, 32'h33440000}, 1'b1);
    check_beat("span_wr_b1", 1, {14'd4, 4'b0011, 32'h00001122}, 1'b1);
    beat_q.delete();
    send(32'h0E, 2'b10, 1'b0, 32'h0, a);
    wait_done();
    check_nbeats("span_rd_beats", 2);
    check_beat("span_rd_b0", 0, {14'd3, 4'b0000, 32'h0}, 1'b0);
    check_beat("span_rd_b1", 1, {14'd4, 4'b0000, 32'h0}, 1'b0);
    send(32'h0F, 2'b01, 1'b0, 32'h0, a);  // half crossing the boundary
    wait_done();
  endtask

  task automatic test_err();
    int a;
    send(32'h0000FFFC, 2'b10, 1'b1, 32'hCAFEF00D, a);
    wait_done();
    beat_q.delete();
    send(32'h00010000, 2'b10, 1'b0, 32'h0, a);
    send(32'h0000FFFF, 2'b01, 1'b1, 32'hAAAA, a);
    send(32'hFFFFFFFE, 2'b01, 1'b0, 32'h0, a);
    wait_done();
    check_nbeats("err_no_beats", 0);
    checks++;
    if (ram[16383] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL err_no_write: ram[3fff]=%h required cafef00d", ram[16383]);
    end
    send(32'h0000FFFC, 2'b10, 1'b0, 32'h0, a);
    wait_done();
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2;
    send(32'h0, 2'b10, 1'b1, 32'h01020304, a0);
    send(32'h4, 2'b10, 1'b1, 32'hA5A55A5A, a0);
    send(32'h8, 2'b10, 1'b1, 32'h7F00FF80, a0);
    wait_done();
    send(32'h0, 2'b10, 1'b0, 32'h0, a0);
    send(32'h4, 2'b10, 1'b0, 32'h0, a1);
    send(32'h8, 2'b10, 1'b0, 32'h0, a2);
    wait_done();
    checks += 2;
    if (a1 - a0 != 4) begin errors++; $display("FAIL b2b_gap01: got %0d required 4", a1 - a0); end
    if (a2 - a1 != 4) begin errors++; $display("FAIL b2b_gap12: got %0d required 4", a2 - a1); end
  endtask

  task automatic test_random();
    int a;
    for (int i = 0; i < 66; i++) send(32'h100 + 32'(4*i), 2'b10, 1'b1, $urandom, a);
    for (int i = 0; i < 40; i++)
      send(32'h100 + 32'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom, a);
    wait_done();
  endtask

  task automatic test_reset_mid();
    int   a;
    logic seen;
    send(32'h2E, 2'b10, 1'b1, 32'h55667788, a);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (dbg_state == ST_B1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL abort_reach_b1: state %0d, required B1", dbg_state); end
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    checks += 3;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL abort_state: got %0d required IDLE", dbg_state); end
    if (ram_en !== 1'b0)       begin errors++; $display("FAIL abort_ram_en: got %b required 0", ram_en); end
    if (rsp_valid !== 1'b0)    begin errors++; $display("FAIL abort_rsp_valid: got %b required 0", rsp_valid); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send(32'h10, 2'b10, 1'b0, 32'h0, a);
    wait_done();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_we    = 1'b0;
    req_wdata = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    fork
      monitor();
    join_none
    test_word();
    test_subword();
    test_span();
    test_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
